// File: rtl/sort_pkg.sv
// sort_pkg: shared FSM encoding, default sizes and sentinel bits for the insertion-sort slice.
// Ports: none (package).
package sort_pkg;
    typedef enum logic [1:0] {LOAD, SETTLE, DRAIN} state_t;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 8;
    // Sentinel bit replicated across a word: all-ones for ascending, zero for descending.
    localparam logic SENT_ASC = 1'b1;
    localparam logic SENT_DESC = 1'b0;
endpackage

// File: rtl/sort_array.sv
// sort_array: chain of DEPTH insertion-sort nodes with tail sentinel tie-off.
// Ports: clk, rst (async active-high), clk_en (advance all nodes), push (1 insert / 0 pop),
//        din (word entering the head node), dout (head node key).
module sort_array import sort_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter bit ASCEND = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam logic [DATA_WIDTH-1:0] SENT = {DATA_WIDTH{ASCEND ? SENT_ASC : SENT_DESC}};
    logic [DATA_WIDTH-1:0] key [DEPTH+1];
    logic [DATA_WIDTH-1:0] cas [DEPTH];
    assign cas[0] = din;
    // A popping tail pulls in the sentinel, so a drained array is clean again.
    assign key[DEPTH] = SENT;
    assign dout = key[0];
    for (genvar n = 0; n < DEPTH; n++) begin : g_node
        logic [DATA_WIDTH-1:0] r;
        logic win;
        assign win = ASCEND ? (cas[n] < r) : (cas[n] > r);
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r <= SENT;
            else if (clk_en)
                r <= push ? (win ? cas[n] : r) : key[n+1];
        end
        assign key[n] = r;
        // The displaced (losing) word ripples on to the next node; the tail's loser is a sentinel.
        if (n < DEPTH - 1) begin : g_fwd
            assign cas[n+1] = win ? r : cas[n];
        end
    end
endmodule

// File: rtl/sort_ctrl.sv
// sort_ctrl: frame sequencer loading words into a sort array and draining them in order.
// Ports: clk_i, rst_n_i (async active-low); s_valid_i/s_ready_o/s_data_i/s_last_i input stream;
//        m_valid_o/m_ready_i/m_data_o/m_last_o sorted stream; arr_clk_en_o/arr_push_o/arr_data_o/
//        arr_data_i array control and head-node data; count_o occupancy; busy_o; overflow_o sticky.
module sort_ctrl import sort_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  arr_clk_en_o,
    output logic                  arr_push_o,
    output logic [DATA_WIDTH-1:0] arr_data_o,
    input  logic [DATA_WIDTH-1:0] arr_data_i,
    output logic [CNT_W-1:0]      count_o,
    output logic                  busy_o,
    output logic                  overflow_o
);
    state_t state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] pop;
    logic overflow;
    logic full_beat;
    // Accepting a word while DEPTH-1 are held fills the array, so LOAD never sees count == DEPTH.
    assign full_beat = count == CNT_W'(DEPTH - 1);
    assign s_ready_o = state == LOAD;
    assign arr_push_o = state == LOAD;
    assign arr_data_o = s_data_i;
    assign m_valid_o = state == DRAIN;
    assign m_data_o = arr_data_i;
    assign m_last_o = m_valid_o && pop == count - CNT_W'(1);
    assign arr_clk_en_o = (s_ready_o && s_valid_i) || (m_valid_o && m_ready_i);
    assign count_o = count;
    assign overflow_o = overflow;
    assign busy_o = !(s_ready_o && count == '0);
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= LOAD;
            count <= '0;
            pop <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                LOAD: if (s_valid_i) begin
                    count <= count + CNT_W'(1);
                    if (s_last_i || full_beat)
                        state <= SETTLE;
                    if (!s_last_i && full_beat)
                        overflow <= 1'b1;
                end
                SETTLE: state <= DRAIN;
                DRAIN: if (m_ready_i) begin
                    if (m_last_o) begin
                        count <= '0;
                        pop <= '0;
                        state <= LOAD;
                    end else begin
                        pop <= pop + CNT_W'(1);
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_ctrl.sv
// tb_sort_ctrl: directed self-checking bench for sort_ctrl driving a sort_array.
module tb_sort_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic m_ready = 1'b0;
    logic [15:0] s_data = '0;
    logic s_ready, m_valid, m_last, arr_clk_en, arr_push, busy, overflow;
    logic [15:0] m_data, arr_data_o, arr_data_i;
    logic [3:0] count;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort_ctrl #(.DATA_WIDTH(16), .DEPTH(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
        .arr_clk_en_o(arr_clk_en), .arr_push_o(arr_push), .arr_data_o(arr_data_o),
        .arr_data_i(arr_data_i), .count_o(count), .busy_o(busy), .overflow_o(overflow)
    );

    sort_array #(.DATA_WIDTH(16), .DEPTH(8), .ASCEND(1'b1)) arr (
        .clk(clk), .rst(~rst_n), .clk_en(arr_clk_en), .push(arr_push),
        .din(arr_data_o), .dout(arr_data_i)
    );

    task automatic push_word(input logic [15:0] d, input logic last);
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (s_ready !== 1'b1 || arr_push !== 1'b1) begin errors++; $display("FAIL reset_load: s_ready %b arr_push %b expected 1 1", s_ready, arr_push); end
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0 || arr_clk_en !== 1'b0) begin errors++; $display("FAIL reset_out: m_valid %b m_last %b clk_en %b expected 0 0 0", m_valid, m_last, arr_clk_en); end
        checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: busy %b overflow %b expected 0 0", busy, overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        logic [15:0] exp [4];
        exp = '{16'd1, 16'd3, 16'd5, 16'd7};
        m_ready = 1'b1;
        push_word(16'd5, 1'b0);
        checks++; if (busy !== 1'b1 || count !== 4'd1) begin errors++; $display("FAIL basic_busy: busy %b count %0d expected 1 1", busy, count); end
        push_word(16'd3, 1'b0);
        push_word(16'd7, 1'b0);
        push_word(16'd1, 1'b1);
        checks++; if (s_ready !== 1'b0 || m_valid !== 1'b0 || arr_push !== 1'b0 || arr_clk_en !== 1'b0) begin errors++; $display("FAIL basic_settle: s_ready %b m_valid %b push %b clk_en %b expected 0 0 0 0", s_ready, m_valid, arr_push, arr_clk_en); end
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL basic_count: got %0d expected 4", count); end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== exp[i] || m_last !== (i == 3) || arr_clk_en !== 1'b1) begin errors++; $display("FAIL basic_out%0d: valid %b data %0d last %b clk_en %b expected 1 %0d %b 1", i, m_valid, m_data, m_last, arr_clk_en, exp[i], i == 3); end
            @(posedge clk);
            #1;
        end
        checks++; if (count !== 4'd0 || s_ready !== 1'b1) begin errors++; $display("FAIL basic_end: count %0d s_ready %b expected 0 1", count, s_ready); end
    endtask

    task automatic test_full;
        for (int i = 0; i < 8; i++) push_word(16'(8 - i), i == 7);
        checks++; if (count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL full_settle: count %0d overflow %b expected 8 0", count, overflow); end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (m_data !== 16'(i + 1) || m_last !== (i == 7)) begin errors++; $display("FAIL full_out%0d: data %0d last %b expected %0d %b", i, m_data, m_last, i + 1, i == 7); end
            @(posedge clk);
            #1;
        end
        checks++; if (overflow !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL full_end: overflow %b count %0d expected 0 0", overflow, count); end
    endtask

    task automatic test_overflow;
        logic [15:0] vals [8];
        vals = '{16'd40, 16'd10, 16'd80, 16'd20, 16'd70, 16'd30, 16'd60, 16'd50};
        for (int i = 0; i < 8; i++) push_word(vals[i], 1'b0);
        checks++; if (s_ready !== 1'b0 || overflow !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL ovf_settle: s_ready %b overflow %b count %0d expected 0 1 8", s_ready, overflow, count); end
        s_valid = 1'b1;
        s_data = 16'd5;
        s_last = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (s_ready !== 1'b0 || m_data !== 16'(10 * (i + 1)) || m_last !== (i == 7)) begin errors++; $display("FAIL ovf_out%0d: s_ready %b data %0d last %b expected 0 %0d %b", i, s_ready, m_data, m_last, 10 * (i + 1), i == 7); end
            @(posedge clk);
            #1;
        end
        checks++; if (s_ready !== 1'b1 || count !== 4'd0 || overflow !== 1'b1 || arr_clk_en !== 1'b1) begin errors++; $display("FAIL ovf_reload: s_ready %b count %0d overflow %b clk_en %b expected 1 0 1 1", s_ready, count, overflow, arr_clk_en); end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
        checks++; if (count !== 4'd1 || s_ready !== 1'b0) begin errors++; $display("FAIL ovf_ninth: count %0d s_ready %b expected 1 0", count, s_ready); end
        @(posedge clk);
        #1;
        checks++; if (m_data !== 16'd5 || m_last !== 1'b1) begin errors++; $display("FAIL ovf_single: data %0d last %b expected 5 1", m_data, m_last); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        logic [15:0] exp [3];
        logic pat [6];
        int idx;
        exp = '{16'd2, 16'd4, 16'd9};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        idx = 0;
        push_word(16'd2, 1'b0);
        push_word(16'd9, 1'b0);
        push_word(16'd4, 1'b1);
        checks++; if (arr_clk_en !== 1'b0) begin errors++; $display("FAIL bp_settle_en: clk_en %b expected 0", arr_clk_en); end
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            m_ready = pat[c];
            #1;
            checks++; if (m_valid !== 1'b1 || m_data !== exp[idx] || m_last !== (idx == 2) || arr_clk_en !== pat[c]) begin errors++; $display("FAIL bp_cycle%0d: valid %b data %0d last %b clk_en %b expected 1 %0d %b %b", c, m_valid, m_data, m_last, arr_clk_en, exp[idx], idx == 2, pat[c]); end
            if (pat[c]) idx++;
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        checks++; if (s_ready !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL bp_end: s_ready %b count %0d expected 1 0", s_ready, count); end
    endtask

    task automatic test_back_to_back;
        push_word(16'hBEEF, 1'b1);
        @(posedge clk);
        #1;
        checks++; if (m_data !== 16'hBEEF || m_last !== 1'b1 || m_valid !== 1'b1) begin errors++; $display("FAIL b2b_single: data %h last %b valid %b expected beef 1 1", m_data, m_last, m_valid); end
        @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_resume: s_ready %b expected 1", s_ready); end
        push_word(16'h0001, 1'b0);
        push_word(16'hFFFE, 1'b1);
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", count); end
        @(posedge clk);
        #1;
        checks++; if (m_data !== 16'h0001 || m_last !== 1'b0) begin errors++; $display("FAIL b2b_out0: data %h last %b expected 0001 0", m_data, m_last); end
        @(posedge clk);
        #1;
        checks++; if (m_data !== 16'hFFFE || m_last !== 1'b1) begin errors++; $display("FAIL b2b_out1: data %h last %b expected fffe 1", m_data, m_last); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        push_word(16'd8, 1'b0);
        push_word(16'd6, 1'b0);
        push_word(16'd4, 1'b0);
        push_word(16'd2, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (m_data !== 16'(2 + 2 * i)) begin errors++; $display("FAIL rmid_out%0d: data %0d expected %0d", i, m_data, 2 + 2 * i); end
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL rmid_out: valid %b last %b count %0d expected 0 0 0", m_valid, m_last, count); end
        checks++; if (s_ready !== 1'b1 || arr_push !== 1'b1 || arr_clk_en !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rmid_ctl: s_ready %b push %b clk_en %b busy %b overflow %b expected 1 1 0 0 0", s_ready, arr_push, arr_clk_en, busy, overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_word(16'd6, 1'b0);
        push_word(16'd2, 1'b1);
        @(posedge clk);
        #1;
        checks++; if (m_data !== 16'd2 || m_last !== 1'b0) begin errors++; $display("FAIL rmid_next0: data %0d last %b expected 2 0", m_data, m_last); end
        @(posedge clk);
        #1;
        checks++; if (m_data !== 16'd6 || m_last !== 1'b1) begin errors++; $display("FAIL rmid_next1: data %0d last %b expected 6 1", m_data, m_last); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full;
        test_overflow;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
